prog_loader: RTL

- Byte-stream writer that fills the processor's instruction memory before execution. It is the write side of the program store that the processor's fetch path (pc + rom) reads.
- Accepts a length byte followed by instruction bytes on a valid/ready stream. It assembles each instruction word and issues single-cycle writes at incrementing addresses.
- Holds the processor halted until a complete, legal program has been written, then raises proc_run.

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package prog_loader_pkg;

    localparam int unsigned BYTES_PER_INSTR = 2;
    localparam int unsigned DEF_ADDR_W      = 5;
    localparam int unsigned DEF_INSTR_W     = 8 * BYTES_PER_INSTR;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_LO,
        ST_HI,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    // Largest legal program length in words for a given address width.
    function automatic int unsigned max_len(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a length byte plus little-endian instruction bytes into the
// instruction memory, holding the processor halted until the load completes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               proc_run,
    output logic               busy,
    output logic               err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = max_len(ADDR_W);

    ld_state_e          state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         lo_q, lo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               run_q, run_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               hs;
    logic [CNT_W-1:0]   cnt_inc;

    assign in_ready = (state_q inside {ST_LEN, ST_LO, ST_HI}) && !load_start;
    assign hs       = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load_start) begin
            state_d = ST_LEN;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LEN: if (hs) begin
                    if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = CNT_W'(in_data);
                        cnt_d   = '0;
                        addr_d  = '0;
                        state_d = ST_LO;
                    end
                end
                ST_LO: if (hs) begin
                    lo_d    = in_data;
                    state_d = ST_HI;
                end
                ST_HI: if (hs) begin
                    wdata_d = INSTR_W'({in_data, lo_q});
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_LO;
                    end
                end
                ST_DONE: ;
                ST_ERR:  ;
                default: state_d = ST_IDLE;
            endcase
        end
        we_d   = (state_d == ST_WRITE);
        run_d  = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
        busy_d = (state_d inside {ST_LEN, ST_LO, ST_HI, ST_WRITE});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // A restart landing on the WRITE cycle suppresses that write.
    assign mem_we    = we_q && !load_start;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign proc_run  = run_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
